// File: rtl/genius_jogo_param_if.sv
// Board-side I/O bundle of the Genius game core.
// Macro GENIUS_DIFICULDADE_EN adds the 'dificuldade' input.
//   master (board/bench): drives jogar, botoes[, dificuldade]; reads display and status.
//   slave  (game core)  : the reverse.
//   jogar        start/restart request (level)
//   botoes       raw player buttons, active-high
//   leds         one-hot playback / button echo
//   rodada       current sequence length
//   pontuacao    rounds completed
//   estado       FSM state code (debug)
//   ganhou/perdeu/fim_timeout/pronto  game outcome flags
interface genius_jogo_param_if #(
    parameter int unsigned N_BOTOES    = 4,
    parameter int unsigned MAX_RODADAS = 16
);
    localparam int unsigned RW = $clog2(MAX_RODADAS + 1);

`ifdef GENIUS_DIFICULDADE_EN
    logic                dificuldade;
`endif
    logic                jogar;
    logic [N_BOTOES-1:0] botoes;
    logic [N_BOTOES-1:0] leds;
    logic [RW-1:0]       rodada;
    logic [RW-1:0]       pontuacao;
    logic [3:0]          estado;
    logic                ganhou;
    logic                perdeu;
    logic                fim_timeout;
    logic                pronto;

    modport master (
`ifdef GENIUS_DIFICULDADE_EN
        output dificuldade,
`endif
        output jogar, botoes,
        input  leds, rodada, pontuacao, estado, ganhou, perdeu, fim_timeout, pronto
    );

    modport slave (
`ifdef GENIUS_DIFICULDADE_EN
        input  dificuldade,
`endif
        input  jogar, botoes,
        output leds, rodada, pontuacao, estado, ganhou, perdeu, fim_timeout, pronto
    );
endinterface

// File: rtl/genius_jogo_param.sv
// Parametrised Genius/Simon game core: LFSR-generated sequence grown by one
// element per round, LED playback, then timed checking of player presses.
// Optional macro: GENIUS_DIFICULDADE_EN (adds 'dificuldade', latched in INIT;
// when 1, playback and timeout limits are halved).
// Ports:
//   clock   system clock, rising edge
//   reset   asynchronous, active-low
//   io      genius_jogo_param_if.slave (buttons, jogar, LEDs, status)
module genius_jogo_param #(
    parameter int unsigned N_BOTOES    = 4,
    parameter int unsigned MAX_RODADAS = 16,
    parameter int unsigned T_MOSTRA    = 25_000_000,
    parameter int unsigned T_TIMEOUT   = 150_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  reset,
    genius_jogo_param_if.slave    io
);
    localparam int unsigned EW       = (N_BOTOES > 1) ? $clog2(N_BOTOES) : 1;
    localparam int unsigned RW       = $clog2(MAX_RODADAS + 1);
    localparam int unsigned AW       = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1;
    localparam int unsigned TMAX     = (T_TIMEOUT > T_MOSTRA) ? T_TIMEOUT : T_MOSTRA;
    localparam int unsigned TW       = $clog2(TMAX + 1);
    localparam int unsigned ON_STD   = (T_MOSTRA > 0) ? T_MOSTRA : 1;
    localparam int unsigned OFF_STD  = (T_MOSTRA / 2 > 0) ? T_MOSTRA / 2 : 1;
    localparam int unsigned TO_STD   = (T_TIMEOUT > 0) ? T_TIMEOUT : 1;
`ifdef GENIUS_DIFICULDADE_EN
    localparam int unsigned ON_FAST  = (T_MOSTRA / 2 > 0) ? T_MOSTRA / 2 : 1;
    localparam int unsigned OFF_FAST = (T_MOSTRA / 4 > 0) ? T_MOSTRA / 4 : 1;
    localparam int unsigned TO_FAST  = (T_TIMEOUT / 2 > 0) ? T_TIMEOUT / 2 : 1;
`endif

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT     = 4'd1,
        S_ADD      = 4'd2,
        S_SHOW_ON  = 4'd3,
        S_SHOW_OFF = 4'd4,
        S_WAIT     = 4'd5,
        S_CHECK    = 4'd6,
        S_NEXT     = 4'd7,
        S_WIN      = 4'd8,
        S_LOSE     = 4'd9,
        S_TIMEOUT  = 4'd10
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                jogar_s1_q, jogar_s2_q, jogar_prev_q;
    logic [N_BOTOES-1:0] botoes_s1_q, botoes_s2_q, botoes_prev_q;
    logic [RW-1:0]       rodada_q, rodada_d;
    logic [RW-1:0]       pontuacao_q, pontuacao_d;
    logic [RW-1:0]       idx_q, idx_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [N_BOTOES-1:0] press_vec_q, press_vec_d;
    logic [N_BOTOES-1:0] leds_q, leds_d;
    logic                ganhou_q, ganhou_d;
    logic                perdeu_q, perdeu_d;
    logic                fim_timeout_q, fim_timeout_d;
    logic                pronto_q, pronto_d;
    logic [EW-1:0]       mem_q [MAX_RODADAS];

    logic                jogar_pulse;
    logic                press;
    logic                mem_we;
    logic [EW-1:0]       new_elem;
    logic [EW-1:0]       rd_elem;
    logic [RW-1:0]       last_idx;
    logic [TW-1:0]       on_last, off_last, to_last;

    function automatic logic [N_BOTOES-1:0] onehot(input logic [EW-1:0] e);
        onehot = N_BOTOES'(1) << e;
    endfunction

`ifdef GENIUS_DIFICULDADE_EN
    logic dif_s1_q, dif_s2_q, dif_q, dif_d;

    // Difficulty is synchronized like any other pin but only latched in INIT
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dif_s1_q <= 1'b0;
            dif_s2_q <= 1'b0;
            dif_q    <= 1'b0;
        end else begin
            dif_s1_q <= io.dificuldade;
            dif_s2_q <= dif_s1_q;
            dif_q    <= dif_d;
        end
    end

    always_comb begin
        dif_d    = (state_q == S_INIT) ? dif_s2_q : dif_q;
        on_last  = dif_q ? TW'(ON_FAST - 1)  : TW'(ON_STD - 1);
        off_last = dif_q ? TW'(OFF_FAST - 1) : TW'(OFF_STD - 1);
        to_last  = dif_q ? TW'(TO_FAST - 1)  : TW'(TO_STD - 1);
    end
`else
    always_comb begin
        on_last  = TW'(ON_STD - 1);
        off_last = TW'(OFF_STD - 1);
        to_last  = TW'(TO_STD - 1);
    end
`endif

    // Input synchronizers plus one history stage for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogar_s1_q    <= 1'b0;
            jogar_s2_q    <= 1'b0;
            jogar_prev_q  <= 1'b0;
            botoes_s1_q   <= '0;
            botoes_s2_q   <= '0;
            botoes_prev_q <= '0;
        end else begin
            jogar_s1_q    <= io.jogar;
            jogar_s2_q    <= jogar_s1_q;
            jogar_prev_q  <= jogar_s2_q;
            botoes_s1_q   <= io.botoes;
            botoes_s2_q   <= botoes_s1_q;
            botoes_prev_q <= botoes_s2_q;
        end
    end

    // A press is any all-zero to non-zero transition of the synced buttons
    always_comb begin
        jogar_pulse = jogar_s2_q & ~jogar_prev_q;
        press       = (|botoes_s2_q) & ~(|botoes_prev_q);
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        new_elem    = EW'(16'(lfsr_q[7:0]) % 16'(N_BOTOES));
        last_idx    = RW'(rodada_q - RW'(1));
    end

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        rodada_d      = rodada_q;
        pontuacao_d   = pontuacao_q;
        idx_d         = idx_q;
        tmr_d         = tmr_q;
        press_vec_d   = press_vec_q;
        ganhou_d      = ganhou_q;
        perdeu_d      = perdeu_q;
        fim_timeout_d = fim_timeout_q;
        pronto_d      = pronto_q;
        mem_we        = 1'b0;
        leds_d        = '0;
        rd_elem       = '0;

        case (state_q)
            S_IDLE: begin
                if (jogar_pulse) state_d = S_INIT;
            end
            S_INIT: begin
                rodada_d      = '0;
                pontuacao_d   = '0;
                idx_d         = '0;
                tmr_d         = '0;
                ganhou_d      = 1'b0;
                perdeu_d      = 1'b0;
                fim_timeout_d = 1'b0;
                pronto_d      = 1'b0;
                state_d       = S_ADD;
            end
            S_ADD: begin
                mem_we   = 1'b1;
                rodada_d = rodada_q + RW'(1);
                idx_d    = '0;
                tmr_d    = '0;
                state_d  = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (tmr_q == on_last) begin
                    tmr_d   = '0;
                    state_d = S_SHOW_OFF;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_SHOW_OFF: begin
                if (tmr_q == off_last) begin
                    tmr_d = '0;
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        idx_d   = idx_q + RW'(1);
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_WAIT: begin
                // A press on the expiry cycle still counts
                if (press) begin
                    press_vec_d = botoes_s2_q;
                    state_d     = S_CHECK;
                end else if (tmr_q == to_last) begin
                    fim_timeout_d = 1'b1;
                    pronto_d      = 1'b1;
                    state_d       = S_TIMEOUT;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_CHECK: begin
                if (press_vec_q != onehot(mem_q[AW'(idx_q)])) begin
                    perdeu_d = 1'b1;
                    pronto_d = 1'b1;
                    state_d  = S_LOSE;
                end else if (idx_q == last_idx) begin
                    state_d = S_NEXT;
                end else begin
                    idx_d   = idx_q + RW'(1);
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_NEXT: begin
                pontuacao_d = pontuacao_q + RW'(1);
                if (rodada_q == RW'(MAX_RODADAS)) begin
                    ganhou_d = 1'b1;
                    pronto_d = 1'b1;
                    state_d  = S_WIN;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_WIN, S_LOSE, S_TIMEOUT: begin
                // Flags drop on the same edge INIT is entered
                if (jogar_pulse) begin
                    ganhou_d      = 1'b0;
                    perdeu_d      = 1'b0;
                    fim_timeout_d = 1'b0;
                    pronto_d      = 1'b0;
                    state_d       = S_INIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // LEDs are registered against the next state so they line up with estado;
        // the element written in ADD is forwarded for the first playback slot.
        if (state_d == S_SHOW_ON) begin
            if (mem_we && (rodada_q == idx_d)) rd_elem = new_elem;
            else                               rd_elem = mem_q[AW'(idx_d)];
            leds_d = onehot(rd_elem);
        end else if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
            leds_d = botoes_s2_q;
        end
    end

    // State and control registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            lfsr_q        <= LFSR_SEED;
            rodada_q      <= '0;
            pontuacao_q   <= '0;
            idx_q         <= '0;
            tmr_q         <= '0;
            press_vec_q   <= '0;
            leds_q        <= '0;
            ganhou_q      <= 1'b0;
            perdeu_q      <= 1'b0;
            fim_timeout_q <= 1'b0;
            pronto_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            rodada_q      <= rodada_d;
            pontuacao_q   <= pontuacao_d;
            idx_q         <= idx_d;
            tmr_q         <= tmr_d;
            press_vec_q   <= press_vec_d;
            leds_q        <= leds_d;
            ganhou_q      <= ganhou_d;
            perdeu_q      <= perdeu_d;
            fim_timeout_q <= fim_timeout_d;
            pronto_q      <= pronto_d;
        end
    end

    // Sequence memory; contents are irrelevant until written in ADD
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[AW'(rodada_q)] <= new_elem;
    end

    assign io.leds        = leds_q;
    assign io.rodada      = rodada_q;
    assign io.pontuacao   = pontuacao_q;
    assign io.estado      = state_q;
    assign io.ganhou      = ganhou_q;
    assign io.perdeu      = perdeu_q;
    assign io.fim_timeout = fim_timeout_q;
    assign io.pronto      = pronto_q;
endmodule

// File: tb/tb_genius_jogo_param.sv
// Testbench for genius_jogo_param: small game (4 buttons, 3 rounds, short timers).
module tb_genius_jogo_param;
    localparam int unsigned NB = 4;
    localparam int unsigned MR = 3;
    localparam int unsigned TM = 8;
    localparam int unsigned TT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    genius_jogo_param_if #(.N_BOTOES(NB), .MAX_RODADAS(MR)) io ();

    genius_jogo_param #(
        .N_BOTOES(NB), .MAX_RODADAS(MR), .T_MOSTRA(TM), .T_TIMEOUT(TT), .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .io(io.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference LFSR, free-running from reset like the game's
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    logic [3:0] last_add;
    logic [3:0] shown [8];
    logic [3:0] saved [8];
    int shown_n;
    int on_cnt;
    int mid_estado;
    int saw_init;
    `ifdef GENIUS_DIFICULDADE_EN
    localparam int unsigned ON_EXP = TM / 2;
    `else
    localparam int unsigned ON_EXP = TM;
    `endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; remembers the element the game appends while in ADD
    task automatic step();
        logic [3:0] one;
        @(posedge clk);
        #1;
        one = 4'b0001;
        if (io.estado == 4'd2) last_add = one << (m_lfsr[7:0] % 8'd4);
        if (io.estado == 4'd1) saw_init++;
    endtask

    task automatic wait_estado(input logic [3:0] tgt, input int budget, input string name);
        int n;
        n = 0;
        while (io.estado != tgt && n < budget) begin
            step();
            n++;
        end
        chk(name, int'(io.estado), int'(tgt));
    endtask

    task automatic do_reset();
        io.botoes = '0;
        io.jogar  = 1'b0;
        rst_n     = 1'b0;
        #1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic start_game();
        io.jogar = 1'b1;
        wait_estado(4'd1, 10, "enter_init");
        io.jogar = 1'b0;
    endtask

    // Record each lit element of the playback until WAIT is reached
    task automatic observe_show();
        int n;
        int prev;
        n = 0;
        prev = 0;
        shown_n = 0;
        on_cnt = 0;
        while (io.estado != 4'd5 && n < 600) begin
            if (io.estado == 4'd3) begin
                if (prev != 3) begin
                    if (shown_n < 8) shown[shown_n] = io.leds;
                    shown_n++;
                end
                on_cnt++;
            end
            prev = int'(io.estado);
            step();
            n++;
        end
        chk("reach_wait", int'(io.estado), 5);
    endtask

    task automatic press(input logic [3:0] v);
        io.botoes = v;
        step();
        step();
        step();
        mid_estado = int'(io.estado);
        step();
        io.botoes = '0;
        step();
        step();
        step();
    endtask

    typedef struct {
        string name;
        int    mode;      // 0 none, 1 correct, 2 wrong, 3 multi-bit
        int    delay;     // cycles in WAIT before driving the buttons
        int    exp_mid;   // estado 3 cycles after the press
        int    exp_est;
        int    exp_pont;
        int    exp_rod;
        int    exp_perdeu;
        int    exp_fim;
        int    exp_pronto;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [3:0] d;
        logic [3:0] v;
        int n;

        vecs[0] = '{"correct",        1,  0,  6, 3, 1, 2, 0, 0, 0};
        vecs[1] = '{"wrong",          2,  5,  6, 9, 0, 1, 1, 0, 1};
        vecs[2] = '{"multi",          3,  2,  6, 9, 0, 1, 1, 0, 1};
        vecs[3] = '{"timeout",        0,  0,  0, 10, 0, 1, 0, 1, 1};
        vecs[4] = '{"press_at_limit", 1, 61,  6, 3, 1, 2, 0, 0, 0};
        vecs[5] = '{"press_too_late", 1, 62, 10, 10, 0, 1, 0, 1, 1};

        io.botoes = '0;
        io.jogar  = 1'b0;
        `ifdef GENIUS_DIFICULDADE_EN
        io.dificuldade = 1'b1;
        `endif
        last_add = '0;
        saw_init = 0;

        // Reset state
        do_reset();
        chk("rst_estado", int'(io.estado), 0);
        chk("rst_leds", int'(io.leds), 0);
        chk("rst_pronto", int'(io.pronto), 0);

        // Reset mid-playback, then restart passes INIT, ADD, SHOW_ON
        start_game();
        wait_estado(4'd3, 10, "show_before_rst");
        rst_n = 1'b0;
        #1;
        chk("midrst_estado", int'(io.estado), 0);
        chk("midrst_leds", int'(io.leds), 0);
        chk("midrst_rodada", int'(io.rodada), 0);
        step();
        rst_n = 1'b1;
        step();
        io.jogar = 1'b1;
        wait_estado(4'd1, 10, "restart_init");
        io.jogar = 1'b0;
        step();
        chk("restart_add", int'(io.estado), 2);
        step();
        chk("restart_show", int'(io.estado), 3);
        chk("restart_rodada", int'(io.rodada), 1);

        // Round-1 vectors
        foreach (vecs[i]) begin
            do_reset();
            start_game();
            observe_show();
            chk({vecs[i].name, "_elem"}, int'(shown[0]), int'(last_add));
            chk({vecs[i].name, "_on_len"}, on_cnt, int'(ON_EXP));
            d = shown[0];
            for (int k = 0; k < vecs[i].delay; k++) step();
            if (vecs[i].mode != 0) begin
                if (vecs[i].mode == 1)      v = d;
                else if (vecs[i].mode == 2) v = {d[2:0], d[3]};
                else                        v = d | {d[2:0], d[3]};
                press(v);
                chk({vecs[i].name, "_mid"}, mid_estado, vecs[i].exp_mid);
            end
            n = 0;
            while (!(io.estado inside {4'd3, 4'd8, 4'd9, 4'd10}) && n < 300) begin
                step();
                n++;
            end
            chk({vecs[i].name, "_estado"}, int'(io.estado), vecs[i].exp_est);
            chk({vecs[i].name, "_pont"}, int'(io.pontuacao), vecs[i].exp_pont);
            chk({vecs[i].name, "_rodada"}, int'(io.rodada), vecs[i].exp_rod);
            chk({vecs[i].name, "_perdeu"}, int'(io.perdeu), vecs[i].exp_perdeu);
            chk({vecs[i].name, "_fim"}, int'(io.fim_timeout), vecs[i].exp_fim);
            chk({vecs[i].name, "_pronto"}, int'(io.pronto), vecs[i].exp_pronto);
        end

        // Full win by replaying the displayed sequence
        do_reset();
        start_game();
        for (int r = 1; r <= int'(MR); r++) begin
            observe_show();
            chk("win_show_count", shown_n, r);
            chk("win_pont_round", int'(io.pontuacao), r - 1);
            chk("win_new_elem", int'(shown[r-1]), int'(last_add));
            for (int k = 0; k < r - 1; k++) chk("win_prefix", int'(shown[k]), int'(saved[k]));
            for (int k = 0; k < r; k++) saved[k] = shown[k];
            for (int k = 0; k < r; k++) press(saved[k]);
        end
        wait_estado(4'd8, 100, "win_estado");
        chk("win_ganhou", int'(io.ganhou), 1);
        chk("win_pronto", int'(io.pronto), 1);
        chk("win_pont", int'(io.pontuacao), 3);
        chk("win_rodada", int'(io.rodada), 3);

        // jogar during playback is ignored; jogar in LOSE restarts
        do_reset();
        start_game();
        step();
        step();
        saw_init = 0;
        io.jogar = 1'b1;
        for (int k = 0; k < 4; k++) step();
        io.jogar = 1'b0;
        observe_show();
        chk("ign_no_init", saw_init, 0);
        chk("ign_rodada", int'(io.rodada), 1);
        d = shown[0];
        press({d[2:0], d[3]});
        wait_estado(4'd9, 20, "ign_lose");
        chk("lose_perdeu", int'(io.perdeu), 1);
        io.jogar = 1'b1;
        wait_estado(4'd1, 10, "lose_restart");
        chk("restart_perdeu", int'(io.perdeu), 0);
        chk("restart_pronto", int'(io.pronto), 0);
        io.jogar = 1'b0;
        observe_show();
        chk("restart_rodada1", int'(io.rodada), 1);
        chk("restart_elem", int'(shown[0]), int'(last_add));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
